// File: rtl/bram_dump_reader_pkg.sv
// ---------------------------------------------------------------------------
// bram_dump_reader_pkg
//   Shared constants and the FSM state type for the BRAM dump reader.
//   Default widths match the rv32i data BRAM: 4 KiB byte window holding
//   32-bit words, with one-cycle registered read latency on the debug port.
//   No ports (package).
// ---------------------------------------------------------------------------
package bram_dump_reader_pkg;

  localparam int DUMP_ADDR_WIDTH = 12;
  localparam int DUMP_DATA_WIDTH = 32;
  localparam int DUMP_RD_LATENCY = 1;
  localparam int DUMP_CNT_WIDTH  = 11;
  localparam int DUMP_WORD_BYTES = 4;

  // 3-bit encoding shared with the rv32i control definitions
  typedef enum logic [2:0] {
    DUMP_IDLE  = 3'd0,
    DUMP_ISSUE = 3'd1,
    DUMP_WAIT  = 3'd2,
    DUMP_HOLD  = 3'd3,
    DUMP_DONE  = 3'd4
  } dump_state_e;

  // The ISSUE cycle already accounts for one cycle of read latency, so WAIT
  // only needs to count the remaining RD_LATENCY-1 cycles down to zero.
  function automatic logic [1:0] lat_preload(input int rd_latency);
    return (rd_latency > 0) ? 2'(rd_latency - 1) : 2'd0;
  endfunction

endpackage

// File: rtl/bram_dump_reader_if.sv
// ---------------------------------------------------------------------------
// bram_dump_reader_if
//   Valid/ready output stream of the dump reader.
//   m_valid  : beat valid (master -> slave)
//   m_ready  : consumer accepts beat when m_valid && m_ready (slave -> master)
//   m_data   : word read from the BRAM
//   m_addr   : byte address the word was read from
// ---------------------------------------------------------------------------
interface bram_dump_reader_if #(
  parameter int ADDR_WIDTH = bram_dump_reader_pkg::DUMP_ADDR_WIDTH,
  parameter int DATA_WIDTH = bram_dump_reader_pkg::DUMP_DATA_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ADDR_WIDTH-1:0] m_addr;

  modport master (output m_valid, output m_data, output m_addr, input m_ready);
  modport slave  (input m_valid, input m_data, input m_addr, output m_ready);

endinterface

// File: rtl/bram_dump_reader.sv
// ---------------------------------------------------------------------------
// bram_dump_reader
//   Reads a contiguous window of a bram32 through its debug read port and
//   streams each word out over valid/ready, one word at a time (no prefetch).
//   Never writes the BRAM and never touches the CPU-owned read port.
// Ports
//   clk, rst    : single rising-edge clock, synchronous active-high reset
//   start       : one-cycle dump request, only honoured in IDLE
//   abort       : cancels a running dump (and blocks a start in IDLE)
//   base_addr   : first byte address, low two bits ignored
//   word_count  : number of words, sampled with start (0 = no beats)
//   debug_addr  : word-aligned address to bram32 debug_addr
//   debug_data  : read data from bram32 debug_data
//   m_if        : output stream (m_valid/m_ready/m_data/m_addr)
//   busy        : high from accepted start until done/abort
//   done        : one-cycle pulse once the last beat has handshaken
// ---------------------------------------------------------------------------
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DUMP_ADDR_WIDTH,
  parameter int DATA_WIDTH = DUMP_DATA_WIDTH,
  parameter int RD_LATENCY = DUMP_RD_LATENCY,
  parameter int CNT_WIDTH  = DUMP_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  bram_dump_reader_if.master    m_if,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(DUMP_WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DUMP_WORD_BYTES - 1);
  localparam logic [1:0]            LAT_LOAD   = lat_preload(RD_LATENCY);
  localparam bit                    ZERO_LAT   = (RD_LATENCY == 0);

  dump_state_e           state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [1:0]            lat_cnt;

  // Dump sequencer. Every output is a register; debug_addr is loaded on the
  // transition into ISSUE so the BRAM sees the address for the whole ISSUE
  // cycle, which is what lets a combinational BRAM be captured in ISSUE.
  // done is raised on leaving DONE, so it appears together with busy=0.
  // An abort in any active state overrides whatever the case statement did,
  // which also suppresses the done pulse and drops a pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DUMP_IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      lat_cnt      <= 2'd0;
      debug_addr   <= '0;
      m_if.m_valid <= 1'b0;
      m_if.m_data  <= '0;
      m_if.m_addr  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (start && !abort) begin
            cur_addr   <= base_addr & ALIGN_MASK;
            debug_addr <= base_addr & ALIGN_MASK;
            remaining  <= word_count;
            busy       <= 1'b1;
            state      <= (word_count == '0) ? DUMP_DONE : DUMP_ISSUE;
          end
        end
        DUMP_ISSUE: begin
          if (ZERO_LAT) begin
            m_if.m_data  <= debug_data;
            m_if.m_addr  <= cur_addr;
            m_if.m_valid <= 1'b1;
            state        <= DUMP_HOLD;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= DUMP_WAIT;
          end
        end
        DUMP_WAIT: begin
          if (lat_cnt == 2'd0) begin
            m_if.m_data  <= debug_data;
            m_if.m_addr  <= cur_addr;
            m_if.m_valid <= 1'b1;
            state        <= DUMP_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        DUMP_HOLD: begin
          if (m_if.m_ready) begin
            m_if.m_valid <= 1'b0;
            remaining    <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state <= DUMP_DONE;
            end else begin
              cur_addr   <= cur_addr + WORD_STEP;
              debug_addr <= cur_addr + WORD_STEP;
              state      <= DUMP_ISSUE;
            end
          end
        end
        DUMP_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DUMP_IDLE;
        end
        default: begin
          state <= DUMP_IDLE;
        end
      endcase

      if (abort && (state != DUMP_IDLE)) begin
        state        <= DUMP_IDLE;
        m_if.m_valid <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_dump_reader
//   Self-checking bench for bram_dump_reader. The main instance uses the
//   default one-cycle read latency; two extra instances with latency 0 and 2
//   replay the basic dump. Expected beats come from a word-level view of the
//   window: beat i reads byte address (base & ~3) + 4*i modulo 4096.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bram_dump_reader;

  logic clk = 1'b0;
  logic rst;

  // main instance (RD_LATENCY = 1)
  logic        start;
  logic        abort;
  logic [11:0] base_addr;
  logic [10:0] word_count;
  logic [11:0] dbg_addr1;
  logic [31:0] dbg_data1;
  logic        busy1;
  logic        done1;

  // latency 0 / latency 2 instances share their own control inputs
  logic        alt_start;
  logic        alt_abort;
  logic [11:0] alt_base;
  logic [10:0] alt_count;
  logic [11:0] dbg_addr0;
  logic [31:0] dbg_data0;
  logic        busy0;
  logic        done0;
  logic [11:0] dbg_addr2;
  logic [31:0] dbg_data2;
  logic [31:0] dbg_pipe2;
  logic        busy2;
  logic        done2;

  logic [31:0] bram_mem [0:1023];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [11:0] q0_addr[$];
  logic [31:0] q0_data[$];
  int          q0_cyc[$];
  logic [11:0] q2_addr[$];
  logic [31:0] q2_data[$];
  int          q2_cyc[$];
  int          done0_cnt = 0;
  int          done2_cnt = 0;

  bram_dump_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mif1 ();
  bram_dump_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mif0 ();
  bram_dump_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) mif2 ();

  bram_dump_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(1), .CNT_WIDTH(11)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .debug_addr(dbg_addr1), .debug_data(dbg_data1),
    .m_if(mif1), .busy(busy1), .done(done1)
  );

  bram_dump_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(0), .CNT_WIDTH(11)) dut_lat0 (
    .clk(clk), .rst(rst), .start(alt_start), .abort(alt_abort),
    .base_addr(alt_base), .word_count(alt_count),
    .debug_addr(dbg_addr0), .debug_data(dbg_data0),
    .m_if(mif0), .busy(busy0), .done(done0)
  );

  bram_dump_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RD_LATENCY(2), .CNT_WIDTH(11)) dut_lat2 (
    .clk(clk), .rst(rst), .start(alt_start), .abort(alt_abort),
    .base_addr(alt_base), .word_count(alt_count),
    .debug_addr(dbg_addr2), .debug_data(dbg_data2),
    .m_if(mif2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  // BRAM debug port models at latency 0, 1 and 2
  assign dbg_data0 = bram_mem[dbg_addr0[11:2]];

  always @(posedge clk) begin
    dbg_data1 <= bram_mem[dbg_addr1[11:2]];
    dbg_pipe2 <= bram_mem[dbg_addr2[11:2]];
    dbg_data2 <= dbg_pipe2;
  end

  // cycle stamp plus beat/done recorders for the alternate-latency instances
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (!rst) begin
      if (mif0.m_valid && mif0.m_ready) begin
        q0_addr.push_back(mif0.m_addr);
        q0_data.push_back(mif0.m_data);
        q0_cyc.push_back(cycle);
      end
      if (mif2.m_valid && mif2.m_ready) begin
        q2_addr.push_back(mif2.m_addr);
        q2_data.push_back(mif2.m_data);
        q2_cyc.push_back(cycle);
      end
      if (done0) done0_cnt <= done0_cnt + 1;
      if (done2) done2_cnt <= done2_cnt + 1;
    end
  end

  // hard stop in case something stalls beyond every bounded wait
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a,
                               input logic [11:0] b, input logic [10:0] c);
    start      = s;
    abort      = a;
    base_addr  = b;
    word_count = c;
  endtask

  function automatic logic [11:0] model_addr(input logic [11:0] b, input int i);
    return 12'((int'(b) & ~3) + 4 * i);
  endfunction

  // Runs one dump on the main instance, stalling each beat for 'stall'
  // cycles, and checks beats, timing, stability and the done/busy ending.
  task automatic run_dump(input string name, input logic [11:0] b,
                          input logic [10:0] c, input int stall);
    logic [11:0] ea;
    logic [31:0] ed;
    int          waited;
    mif1.m_ready = (stall == 0);
    applyStimulus(1'b1, 1'b0, b, c);
    tick();
    applyStimulus(1'b0, 1'b0, b, c);
    checkOutput({name, " busy_after_start"}, 64'(busy1), 64'd1);
    if (c == 11'd0) begin
      checkOutput({name, " no_beat"}, 64'(mif1.m_valid), 64'd0);
      checkOutput({name, " done_early"}, 64'(done1), 64'd0);
      tick();
      checkOutput({name, " done_pulse"}, 64'(done1), 64'd1);
      checkOutput({name, " busy_end"}, 64'(busy1), 64'd0);
      checkOutput({name, " no_beat2"}, 64'(mif1.m_valid), 64'd0);
      tick();
      checkOutput({name, " done_clear"}, 64'(done1), 64'd0);
      return;
    end
    for (int i = 0; i < int'(c); i++) begin
      ea = model_addr(b, i);
      ed = bram_mem[ea[11:2]];
      waited = 0;
      while (!mif1.m_valid && waited < 8) begin
        tick();
        waited++;
      end
      if (!mif1.m_valid) begin
        checkOutput({name, " beat_timeout"}, 64'd0, 64'd1);
        mif1.m_ready = 1'b0;
        return;
      end
      checkOutput({name, " beat_latency"}, 64'(waited), 64'd2);
      checkOutput({name, " m_addr"}, 64'(mif1.m_addr), 64'(ea));
      checkOutput({name, " m_data"}, 64'(mif1.m_data), 64'(ed));
      for (int s = 0; s < stall; s++) begin
        tick();
        checkOutput({name, " stall_valid"}, 64'(mif1.m_valid), 64'd1);
        checkOutput({name, " stall_addr"}, 64'(mif1.m_addr), 64'(ea));
        checkOutput({name, " stall_data"}, 64'(mif1.m_data), 64'(ed));
      end
      mif1.m_ready = 1'b1;
      tick();
      mif1.m_ready = (stall == 0);
      checkOutput({name, " valid_drop"}, 64'(mif1.m_valid), 64'd0);
    end
    checkOutput({name, " done_early"}, 64'(done1), 64'd0);
    checkOutput({name, " busy_last"}, 64'(busy1), 64'd1);
    tick();
    checkOutput({name, " done_pulse"}, 64'(done1), 64'd1);
    checkOutput({name, " busy_end"}, 64'(busy1), 64'd0);
    tick();
    checkOutput({name, " done_clear"}, 64'(done1), 64'd0);
  endtask

  initial begin
    logic [11:0] rb;
    logic [10:0] rc;
    int          waited;

    rst       = 1'b1;
    alt_start = 1'b0;
    alt_abort = 1'b0;
    alt_base  = '0;
    alt_count = '0;
    mif1.m_ready = 1'b0;
    mif0.m_ready = 1'b1;
    mif2.m_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 12'h0, 11'd0);
    for (int i = 0; i < 1024; i++) bram_mem[i] = $urandom;
    bram_mem[0] = 32'h0000000A;
    bram_mem[1] = 32'h00000005;
    tick();
    tick();

    // reset values
    checkOutput("rst debug_addr", 64'(dbg_addr1), 64'd0);
    checkOutput("rst m_valid", 64'(mif1.m_valid), 64'd0);
    checkOutput("rst m_data", 64'(mif1.m_data), 64'd0);
    checkOutput("rst m_addr", 64'(mif1.m_addr), 64'd0);
    checkOutput("rst busy", 64'(busy1), 64'd0);
    checkOutput("rst done", 64'(done1), 64'd0);
    rst = 1'b0;
    tick();

    // basic, stalled, wrapping and empty dumps
    run_dump("t1", 12'h000, 11'd2, 0);
    run_dump("t2", 12'h000, 11'd2, 5);
    bram_mem[1023] = 32'hCAFE0FFC;
    run_dump("t3", 12'hFFE, 11'd2, 1);
    run_dump("t4", 12'h100, 11'd0, 0);

    // reset while a beat is held
    mif1.m_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'h040, 11'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 12'h040, 11'd3);
    waited = 0;
    while (!mif1.m_valid && waited < 8) begin
      tick();
      waited++;
    end
    checkOutput("t5 hold_reached", 64'(mif1.m_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5 debug_addr", 64'(dbg_addr1), 64'd0);
    checkOutput("t5 m_valid", 64'(mif1.m_valid), 64'd0);
    checkOutput("t5 m_data", 64'(mif1.m_data), 64'd0);
    checkOutput("t5 m_addr", 64'(mif1.m_addr), 64'd0);
    checkOutput("t5 busy", 64'(busy1), 64'd0);
    checkOutput("t5 done", 64'(done1), 64'd0);
    tick();
    run_dump("t5b", 12'h200, 11'd2, 0);

    // second start ignored, abort during WAIT
    mif1.m_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 12'h080, 11'd3);
    tick();
    applyStimulus(1'b1, 1'b0, 12'h300, 11'd5);
    tick();
    checkOutput("t6 debug_addr_kept", 64'(dbg_addr1), 64'h080);
    checkOutput("t6 busy_wait", 64'(busy1), 64'd1);
    applyStimulus(1'b0, 1'b1, 12'h300, 11'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 12'h300, 11'd5);
    checkOutput("t6 busy_abort", 64'(busy1), 64'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t6 no_valid", 64'(mif1.m_valid), 64'd0);
      checkOutput("t6 no_done", 64'(done1), 64'd0);
      checkOutput("t6 idle", 64'(busy1), 64'd0);
      tick();
    end

    // start and abort together in IDLE
    applyStimulus(1'b1, 1'b1, 12'h010, 11'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 12'h010, 11'd2);
    checkOutput("t7 busy", 64'(busy1), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t7 no_valid", 64'(mif1.m_valid), 64'd0);
    end

    // randomized dumps, then a run longer than the window
    for (int i = 0; i < 1024; i++) bram_mem[i] = $urandom;
    for (int n = 0; n < 8; n++) begin
      rb = 12'($urandom);
      rc = 11'($urandom_range(1, 8));
      run_dump("rnd", rb, rc, int'($urandom_range(0, 3)));
    end
    run_dump("wrap", 12'hFF9, 11'd1027, 0);

    // latency 0 and 2 instances replay the basic dump
    bram_mem[0] = 32'h0000000A;
    bram_mem[1] = 32'h00000005;
    alt_base  = 12'h000;
    alt_count = 11'd2;
    alt_start = 1'b1;
    tick();
    alt_start = 1'b0;
    waited = 0;
    while ((done0_cnt == 0 || done2_cnt == 0) && waited < 40) begin
      tick();
      waited++;
    end
    tick();
    checkOutput("lat0 beats", 64'(q0_addr.size()), 64'd2);
    checkOutput("lat2 beats", 64'(q2_addr.size()), 64'd2);
    checkOutput("lat0 done_count", 64'(done0_cnt), 64'd1);
    checkOutput("lat2 done_count", 64'(done2_cnt), 64'd1);
    if (q0_addr.size() == 2 && q2_addr.size() == 2) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput("lat0 m_addr", 64'(q0_addr[i]), 64'(model_addr(12'h000, i)));
        checkOutput("lat0 m_data", 64'(q0_data[i]), 64'(bram_mem[i]));
        checkOutput("lat2 m_addr", 64'(q2_addr[i]), 64'(model_addr(12'h000, i)));
        checkOutput("lat2 m_data", 64'(q2_data[i]), 64'(bram_mem[i]));
      end
      checkOutput("lat0 spacing", 64'(q0_cyc[1] - q0_cyc[0]), 64'd2);
      checkOutput("lat2 spacing", 64'(q2_cyc[1] - q2_cyc[0]), 64'd4);
    end
    checkOutput("lat0 busy_end", 64'(busy0), 64'd0);
    checkOutput("lat2 busy_end", 64'(busy2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
